// File: rtl/hd6309_avalon_arbiter.sv
// hd6309_avalon_arbiter: two-port Avalon-MM arbiter (CPU bridge on port 0, loader/DMA on port 1) onto one downstream port.
// Define HD6309_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module hd6309_avalon_arbiter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] s0_address,
   input  logic             s0_read,
   input  logic             s0_write,
   input  logic [7:0]       s0_writedata,
   output logic [7:0]       s0_readdata,
   output logic             s0_waitrequest,
   input  logic [WIDTH-1:0] s1_address,
   input  logic             s1_read,
   input  logic             s1_write,
   input  logic [7:0]       s1_writedata,
   output logic [7:0]       s1_readdata,
   output logic             s1_waitrequest,
   output logic [WIDTH-1:0] m_address,
   output logic             m_read,
   output logic             m_write,
   output logic [7:0]       m_writedata,
   input  logic [7:0]       m_readdata,
   input  logic             m_waitrequest,
   output logic [1:0]       grant
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state;
   logic req0, req1, win1;
   assign req0 = s0_read | s0_write;
   assign req1 = s1_read | s1_write;
`ifdef HD6309_ARB_ROUND_ROBIN_EN
   logic last_served;
   assign win1 = req1 & (~req0 | ~last_served);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) last_served <= 1'b0;
      else if (state == IDLE && (req0 | req1)) last_served <= win1;
`else
   assign win1 = req1 & ~req0;
`endif
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         grant          <= 2'b00;
         m_address      <= '0;
         m_writedata    <= 8'h00;
         m_read         <= 1'b0;
         m_write        <= 1'b0;
         s0_readdata    <= 8'h00;
         s1_readdata    <= 8'h00;
         s0_waitrequest <= 1'b1;
         s1_waitrequest <= 1'b1;
      end else begin
         case (state)
            IDLE: if (req0 | req1) begin
               state       <= BUSY;
               grant       <= win1 ? 2'b10 : 2'b01;
               m_address   <= win1 ? s1_address : s0_address;
               m_writedata <= win1 ? s1_writedata : s0_writedata;
               m_write     <= win1 ? s1_write : s0_write;
               m_read      <= win1 ? (s1_read & ~s1_write) : (s0_read & ~s0_write);
            end
            BUSY: if (!m_waitrequest) begin
               state          <= DONE;
               m_read         <= 1'b0;
               m_write        <= 1'b0;
               s0_waitrequest <= ~grant[0];
               s1_waitrequest <= ~grant[1];
               if (m_read && grant[0]) s0_readdata <= m_readdata;
               if (m_read && grant[1]) s1_readdata <= m_readdata;
            end
            default: begin
               state          <= IDLE;
               grant          <= 2'b00;
               s0_waitrequest <= 1'b1;
               s1_waitrequest <= 1'b1;
            end
         endcase
      end
   end
endmodule
